// File: rtl/uart_hex_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_hex_sender
// Brief    : Formats a captured 64-bit word as lowercase ASCII hex plus CR/LF
//            and streams it byte by byte over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_hex_sender #(
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdata_snd_start,
    input  logic [63:0] rdata_snd,
    input  logic        pc_print_sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        flushing_wq,
    output logic        sender_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIG0 = 3'd1,
        S_SEPR = 3'd2,
        S_DIG1 = 3'd3,
        S_CR   = 3'd4,
        S_LF   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [63:0] r_shadow;
    logic        r_short;

    logic        w_fire;
    logic [31:0] w_word;
    logic [2:0]  w_idx;
    logic [3:0]  w_nib;
    logic [7:0]  w_hex;

    // Digits go out MSB nibble first, so the counter indexes from the top.
    always_comb begin
        w_word = (r_state == S_DIG1) ? r_shadow[63:32] : r_shadow[31:0];
        w_idx  = 3'd7 - r_cnt;
        w_nib  = w_word[{w_idx, 2'b00} +: 4];
        w_hex  = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                 : (8'h57 + {4'h0, w_nib});
    end

    assign w_fire      = tx_valid & tx_ready;
    assign sender_busy = (r_state != S_IDLE);

    always_comb begin
        w_next      = r_state;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        flushing_wq = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rdata_snd_start) w_next = S_DIG0;
            end
            S_DIG0: begin
                tx_valid = 1'b1;
                tx_data  = w_hex;
                if (w_fire && r_cnt == 3'd7) w_next = r_short ? S_CR : S_SEPR;
            end
            S_SEPR: begin
                tx_valid = 1'b1;
                tx_data  = SEP_CHAR;
                if (w_fire) w_next = S_DIG1;
            end
            S_DIG1: begin
                tx_valid = 1'b1;
                tx_data  = w_hex;
                if (w_fire && r_cnt == 3'd7) w_next = S_CR;
            end
            S_CR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0D;
                if (w_fire) w_next = S_LF;
            end
            S_LF: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (w_fire) w_next = S_DONE;
            end
            S_DONE: begin
                flushing_wq = 1'b1;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Shadow and mode are only loaded in IDLE so a line in flight is immune
    // to input changes; the counter wraps naturally after the 8th digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_shadow <= 64'h0;
            r_short  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && rdata_snd_start) begin
                r_shadow <= rdata_snd;
                r_short  <= pc_print_sel;
                r_cnt    <= 3'd0;
            end else if (w_fire && (r_state == S_DIG0 || r_state == S_DIG1)) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire
